// File: rtl/csa_resolver_if.sv
// csa_resolver_if: operand and result valid/ready bundle for csa_resolver.
// master drives operands and out_ready; slave is the resolver.
interface csa_resolver_if #(
    parameter int W = 8
);
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] s_in;
    logic [W-1:0] c_in;
    logic         cin;
    logic         out_valid;
    logic         out_ready;
    logic [W+1:0] result;
    logic         busy;

    modport master (
        output in_valid,
        output s_in,
        output c_in,
        output cin,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  result,
        input  busy
    );

    modport slave (
        input  in_valid,
        input  s_in,
        input  c_in,
        input  cin,
        input  out_ready,
        output in_ready,
        output out_valid,
        output result,
        output busy
    );
endinterface

// File: rtl/csa_resolver.sv
// csa_resolver: resolves (sum, carry, cin) to binary, CHUNK bits per clock.
// Optional CSA_RESOLVER_EARLY_EXIT_EN finishes once no carries remain.
module csa_resolver #(
    parameter int W     = 8,
    parameter int CHUNK = 4
) (
    input logic           clk,
    input logic           rst_n,
    csa_resolver_if.slave bus
);

    localparam int N  = (W + CHUNK) / CHUNK;
    localparam int P  = N * CHUNK;
    localparam int RW = W + 2;
    localparam int KW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RESOLVE,
        DONE
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic [P-1:0]    a_q;
    logic [P-1:0]    a_d;
    logic [P-1:0]    b_q;
    logic [P-1:0]    b_d;
    logic [RW-1:0]   res_q;
    logic [RW-1:0]   res_d;
    logic            carry_q;
    logic            carry_d;
    logic [KW-1:0]   k_q;
    logic [KW-1:0]   k_d;

    logic [31:0]     off;
    logic [CHUNK-1:0] a_chk;
    logic [CHUNK-1:0] b_chk;
    logic [CHUNK:0]  csum;
    logic [P-1:0]    chk_mask;
    logic [P-1:0]    step;
    logic            last;

`ifdef CSA_RESOLVER_EARLY_EXIT_EN
    logic [P-1:0]    lo_mask;
    logic [P-1:0]    step_ee;
    logic            early;
`endif

    // Current chunk slice and its sum with the running carry.
    always_comb begin
        off      = 32'(k_q) * 32'(CHUNK);
        a_chk    = CHUNK'(a_q >> off);
        b_chk    = CHUNK'(b_q >> off);
        csum     = {1'b0, a_chk} + {1'b0, b_chk}
                 + {{CHUNK{1'b0}}, carry_q};
        chk_mask = P'({CHUNK{1'b1}}) << off;
        step     = (P'(res_q) & ~chk_mask)
                 | (P'(csum[CHUNK-1:0]) << off);
        last     = (k_q == KW'(N - 1));
    end

`ifdef CSA_RESOLVER_EARLY_EXIT_EN
    // No B bits above this chunk and no carry out: A passes through.
    always_comb begin
        lo_mask = ~({P{1'b1}} << (off + 32'(CHUNK)));
        step_ee = (step & lo_mask) | (a_q & ~lo_mask);
        early   = ((b_q >> (off + 32'(CHUNK))) == '0)
               && !csum[CHUNK];
    end
`endif

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        carry_d = carry_q;
        k_d     = k_q;
        unique case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    a_d     = P'(bus.s_in);
                    b_d     = P'({bus.c_in, bus.cin});
                    carry_d = 1'b0;
                    k_d     = '0;
                    state_d = RESOLVE;
                end
            end
            RESOLVE: begin
                // Top bit tracks the carry so it lands at W+1 when P == W+1.
                res_d   = RW'({csum[CHUNK], step});
                carry_d = csum[CHUNK];
                k_d     = k_q + 1'b1;
                if (last) begin
                    state_d = DONE;
                end
`ifdef CSA_RESOLVER_EARLY_EXIT_EN
                else if (early) begin
                    res_d   = RW'({csum[CHUNK], step_ee});
                    state_d = DONE;
                end
`endif
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            k_q     <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            carry_q <= carry_d;
            k_q     <= k_d;
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.busy      = (state_q != IDLE);
    assign bus.result    = res_q;

endmodule

// File: tb/tb_csa_resolver.sv
// tb_csa_resolver: directed and random checks of csa_resolver against an
// arithmetic reference, across several W/CHUNK configurations.
module tb_csa_resolver;

    localparam int NI   = 4;
    localparam int WS[NI] = '{8, 8, 8, 16};
    localparam int CS[NI] = '{4, 4, 3, 1};
    localparam int NOPS = 1000;
`ifdef CSA_RESOLVER_EARLY_EXIT_EN
    localparam bit EE = 1'b1;
`else
    localparam bit EE = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic       rst0;
    logic       rstr;
    logic       d_valid;
    logic [7:0] d_s;
    logic [7:0] d_c;
    logic       d_cin;
    logic       d_ordy;

    logic        rst_a [NI];
    logic        iv    [NI];
    logic        ir    [NI];
    logic        ov    [NI];
    logic        ordy  [NI];
    logic        bsy   [NI];
    logic        icin  [NI];
    logic [63:0] sv    [NI];
    logic [63:0] cv    [NI];
    logic [63:0] ores  [NI];
    logic        fin   [NI];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input int inst,
                       input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s [inst %0d]: got 0x%0h, expected 0x%0h",
                     nm, inst, act, exp);
        end
    endtask

    // Cycles from accept to out_valid, from the arithmetic alone.
    function automatic int exp_lat(input longint unsigned a,
                                   input longint unsigned b,
                                   input int ch, input int w);
        int n;
        n = (w + ch) / ch;
        for (int k = 0; k < n; k++) begin
            int m;
            longint unsigned msk;
            m   = (k + 1) * ch;
            msk = (64'd1 << m) - 64'd1;
            if (EE && (b >> m) == 0
                && (((a & msk) + (b & msk)) >> m) == 0)
                return k + 1;
        end
        return n;
    endfunction

    genvar g;
    generate
        for (g = 0; g < NI; g++) begin : u
            localparam int GW = WS[g];
            localparam int GC = CS[g];
            logic rst_l;
            csa_resolver_if #(.W(GW)) bus ();
            csa_resolver #(.W(GW), .CHUNK(GC)) dut (
                .clk  (clk),
                .rst_n(rst_l),
                .bus  (bus)
            );
            if (g == 0) begin : dir
                assign rst_l         = rst0;
                assign bus.in_valid  = d_valid;
                assign bus.s_in      = d_s;
                assign bus.c_in      = d_c;
                assign bus.cin       = d_cin;
                assign bus.out_ready = d_ordy;
                assign fin[g]        = 1'b1;
            end else begin : rnd
                logic done_l = 1'b0;
                assign rst_l  = rstr;
                assign fin[g] = done_l;
                initial begin
                    int acc;
                    int md;
                    bit took;
                    acc = 0;
                    bus.in_valid  = 1'b0;
                    bus.s_in      = '0;
                    bus.c_in      = '0;
                    bus.cin       = 1'b0;
                    bus.out_ready = 1'b0;
                    while (rstr !== 1'b1) @(posedge clk);
                    #1;
                    while (acc < NOPS) begin
                        @(negedge clk);
                        took = bus.in_valid && bus.in_ready;
                        @(posedge clk);
                        #1;
                        if (took) acc++;
                        if (acc == NOPS) break;
                        bus.in_valid = ($urandom_range(0, 3) != 0);
                        md = $urandom_range(0, 7);
                        bus.s_in = (md == 0) ? {GW{1'b1}} :
                                   (md == 1) ? {GW{1'b0}} : GW'($urandom);
                        md = $urandom_range(0, 7);
                        bus.c_in = (md == 0) ? {GW{1'b1}} :
                                   (md == 1) ? {GW{1'b0}} : GW'($urandom);
                        bus.cin  = 1'($urandom);
                        bus.out_ready = ($urandom_range(0, 3) != 0);
                    end
                    bus.in_valid  = 1'b0;
                    bus.out_ready = 1'b1;
                    repeat (GW + 10) @(posedge clk);
                    done_l = 1'b1;
                end
            end
            assign rst_a[g] = rst_l;
            assign iv[g]    = bus.in_valid;
            assign ir[g]    = bus.in_ready;
            assign ov[g]    = bus.out_valid;
            assign ordy[g]  = bus.out_ready;
            assign bsy[g]   = bus.busy;
            assign icin[g]  = bus.cin;
            assign sv[g]    = 64'(bus.s_in);
            assign cv[g]    = 64'(bus.c_in);
            assign ores[g]  = 64'(bus.result);
        end
    endgenerate

    // Reference: one pending operand per instance, value and latency
    // computed arithmetically when the accept is seen.
    bit              rp   [NI] = '{default: 1'b1};
    bit              pv   [NI] = '{default: 1'b0};
    bit              pend [NI] = '{default: 1'b0};
    longint unsigned pval [NI];
    int              plat [NI];
    int              pcyc [NI];
    int              pops [NI] = '{default: 0};

    always @(negedge clk) begin
        for (int i = 0; i < NI; i++) begin
            if (rp[i]) begin
                chk("reset_state", i,
                    64'({ir[i], ov[i], bsy[i], (ores[i] != 64'd0)}),
                    64'(4'b1000));
            end else begin
                chk("in_ready", i, 64'(ir[i]), 64'(!pend[i]));
                chk("busy", i, 64'(bsy[i]), 64'(pend[i]));
                if (ov[i]) begin
                    chk("valid_with_pending", i, 64'(pend[i]), 64'd1);
                    if (pend[i]) begin
                        chk("result", i, ores[i], pval[i]);
                        if (!pv[i])
                            chk("latency", i, 64'(cyc - pcyc[i] - 1),
                                64'(plat[i]));
                    end
                end
            end
            if (rst_a[i] !== 1'b1) begin
                rp[i]   = 1'b1;
                pend[i] = 1'b0;
                pv[i]   = 1'b0;
            end else begin
                rp[i] = 1'b0;
                if (ov[i] && ordy[i] && pend[i]) begin
                    pend[i] = 1'b0;
                    pops[i]++;
                end
                if (iv[i] && ir[i]) begin
                    chk("single_outstanding", i, 64'(pend[i]), 64'd0);
                    pend[i] = 1'b1;
                    pval[i] = sv[i] + 2 * cv[i] + 64'(icin[i]);
                    plat[i] = exp_lat(sv[i], (cv[i] << 1) | 64'(icin[i]),
                                      CS[i], WS[i]);
                    pcyc[i] = cyc;
                end
                pv[i] = ov[i];
            end
        end
    end

    task automatic send(input logic [7:0] s, input logic [7:0] c,
                        input logic ci);
        d_valid = 1'b1;
        d_s     = s;
        d_c     = c;
        d_cin   = ci;
        @(negedge clk);
        chk("accept_ready", 0, 64'(ir[0]), 64'd1);
        @(posedge clk);
        #1;
        d_valid = 1'b0;
        d_s     = 8'($urandom);
        d_c     = 8'($urandom);
        d_cin   = 1'($urandom);
    endtask

    task automatic wait_out(output int lat);
        lat = 0;
        forever begin
            @(negedge clk);
            if (ov[0]) break;
            chk("ready_low_while_busy", 0, 64'(ir[0]), 64'd0);
            lat++;
            if (lat > 24) begin
                chk("out_valid_timeout", 0, 64'd0, 64'd1);
                break;
            end
        end
    endtask

    localparam int SMALL_LAT = EE ? 1 : 3;

    initial begin
        int lat;
        bit all_done;
        rst0    = 1'b0;
        rstr    = 1'b0;
        d_valid = 1'b0;
        d_s     = '0;
        d_c     = '0;
        d_cin   = 1'b0;
        d_ordy  = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst0 = 1'b1;
        rstr = 1'b1;
        @(negedge clk);
        chk("idle_in_ready", 0, 64'(ir[0]), 64'd1);
        chk("idle_out_valid", 0, 64'(ov[0]), 64'd0);
        chk("idle_busy", 0, 64'(bsy[0]), 64'd0);
        chk("idle_result", 0, ores[0], 64'd0);
        @(posedge clk);
        #1;

        send(8'hFF, 8'hFF, 1'b1);
        wait_out(lat);
        chk("chain_latency", 0, 64'(lat), 64'd3);
        chk("chain_result", 0, ores[0], 64'h2FE);
        @(posedge clk);
        #1;

        send(8'h05, 8'h01, 1'b0);
        wait_out(lat);
        chk("small_latency", 0, 64'(lat), 64'(SMALL_LAT));
        chk("small_result", 0, ores[0], 64'h007);
        @(posedge clk);
        #1;

        d_ordy = 1'b0;
        send(8'h80, 8'h40, 1'b1);
        wait_out(lat);
        chk("bp_latency", 0, 64'(lat), 64'd3);
        chk("bp_result", 0, ores[0], 64'h101);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            d_valid = ((i % 2) == 0);
            d_s     = 8'($urandom);
            d_c     = 8'($urandom);
            @(negedge clk);
            chk("bp_hold_valid", 0, 64'(ov[0]), 64'd1);
            chk("bp_hold_result", 0, ores[0], 64'h101);
        end
        @(posedge clk);
        #1;
        d_valid = 1'b0;
        d_ordy  = 1'b1;
        @(negedge clk);
        chk("bp_valid_until_edge", 0, 64'(ov[0]), 64'd1);
        @(negedge clk);
        chk("bp_released", 0, 64'({ov[0], ir[0]}), 64'(2'b01));
        chk("bp_result_persists", 0, ores[0], 64'h101);
        @(posedge clk);
        #1;

        send(8'hAA, 8'h55, 1'b0);
        @(posedge clk);
        #1;
        rst0 = 1'b0;
        @(posedge clk);
        #1;
        rst0 = 1'b1;
        @(negedge clk);
        chk("midrst_out_valid", 0, 64'(ov[0]), 64'd0);
        chk("midrst_in_ready", 0, 64'(ir[0]), 64'd1);
        chk("midrst_result", 0, ores[0], 64'd0);
        @(posedge clk);
        #1;
        send(8'h01, 8'h00, 1'b1);
        wait_out(lat);
        chk("post_rst_latency", 0, 64'(lat), 64'(SMALL_LAT));
        chk("post_rst_result", 0, ores[0], 64'h002);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        chk("directed_ops", 0, 64'(pops[0]), 64'd4);

        all_done = 1'b0;
        for (int t = 0; t < 80000; t++) begin
            all_done = fin[1] && fin[2] && fin[3];
            if (all_done) break;
            @(posedge clk);
        end
        chk("random_done", 0, 64'(all_done), 64'd1);
        for (int i = 1; i < NI; i++)
            chk("random_ops", i, 64'(pops[i]), 64'(NOPS));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
